// File: rtl/montgomery_exp_if.sv
// Multiplier handshake bundle between the exponentiation controller (master)
// and a Montgomery multiplier (slave).
interface montgomery_exp_if #(
  parameter int unsigned WIDTH = 1024
);
  logic             mm_start;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic [WIDTH-1:0] mm_m;
  logic [WIDTH-1:0] mm_result;
  logic             mm_done;

  modport master (
    output mm_start, mm_a, mm_b, mm_m,
    input  mm_result, mm_done
  );

  modport slave (
    input  mm_start, mm_a, mm_b, mm_m,
    output mm_result, mm_done
  );
endinterface

// File: rtl/montgomery_exp.sv
// Left-to-right square-and-multiply modular exponentiation controller that
// sequences an external Montgomery multiplier through its start/done handshake.
module montgomery_exp #(
  parameter int unsigned WIDTH     = 1024,
  parameter int unsigned EXP_WIDTH = 1024
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r_mod_m,
  input  logic [WIDTH-1:0]     in_r2_mod_m,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  montgomery_exp_if.master     mm
);

  localparam int unsigned    CW       = $clog2(EXP_WIDTH) + 1;
  localparam logic [CW-1:0]  CNT_INIT = CW'(EXP_WIDTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOMONT,
    S_SKIP,
    S_SQUARE,
    S_MULT,
    S_NEXT,
    S_FROMMONT,
    S_DONE
  } state_t;

  state_t               state;
  logic                 waiting;
  logic [WIDTH-1:0]     x_mont;
  logic [WIDTH-1:0]     acc;
  logic [EXP_WIDTH-1:0] e_sh;
  logic [CW-1:0]        cnt;
  logic                 e_msb;
  logic                 last_bit;

  assign e_msb    = e_sh[EXP_WIDTH-1];
  assign last_bit = (cnt == CNT_ONE);

  // Operands and mm_start are loaded on the edge that enters a multiply state,
  // so that state's first cycle is the issue phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      waiting     <= 1'b0;
      x_mont      <= '0;
      acc         <= '0;
      e_sh        <= '0;
      cnt         <= '0;
      result      <= '0;
      done        <= 1'b0;
      mm.mm_start <= 1'b0;
      mm.mm_a     <= '0;
      mm.mm_b     <= '0;
      mm.mm_m     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            e_sh        <= in_e;
            cnt         <= CNT_INIT;
            // acc takes the Montgomery one now; nothing touches it before SKIP
            acc         <= in_r_mod_m;
            done        <= 1'b0;
            waiting     <= 1'b0;
            mm.mm_m     <= in_m;
            mm.mm_a     <= in_x;
            mm.mm_b     <= in_r2_mod_m;
            mm.mm_start <= 1'b1;
            state       <= S_TOMONT;
          end
        end

        S_SKIP: begin
          if (e_msb) begin
            mm.mm_a     <= acc;
            mm.mm_b     <= acc;
            mm.mm_start <= 1'b1;
            state       <= S_SQUARE;
          end else begin
            e_sh <= e_sh << 1;
            cnt  <= cnt - CNT_ONE;
            if (last_bit) begin
              mm.mm_a     <= acc;
              mm.mm_b     <= ONE;
              mm.mm_start <= 1'b1;
              state       <= S_FROMMONT;
            end
          end
        end

        S_NEXT: begin
          e_sh        <= e_sh << 1;
          cnt         <= cnt - CNT_ONE;
          mm.mm_a     <= acc;
          mm.mm_b     <= last_bit ? ONE : acc;
          mm.mm_start <= 1'b1;
          state       <= last_bit ? S_FROMMONT : S_SQUARE;
        end

        S_TOMONT, S_SQUARE, S_MULT, S_FROMMONT: begin
          if (!waiting) begin
            mm.mm_start <= 1'b0;
            waiting     <= 1'b1;
          end else if (mm.mm_done) begin
            waiting <= 1'b0;
            case (state)
              S_TOMONT: begin
                x_mont <= mm.mm_result;
                state  <= S_SKIP;
              end
              S_SQUARE: begin
                acc <= mm.mm_result;
                if (e_msb) begin
                  mm.mm_a     <= mm.mm_result;
                  mm.mm_b     <= x_mont;
                  mm.mm_start <= 1'b1;
                  state       <= S_MULT;
                end else begin
                  state <= S_NEXT;
                end
              end
              S_MULT: begin
                acc   <= mm.mm_result;
                state <= S_NEXT;
              end
              default: begin
                result <= mm.mm_result;
                state  <= S_DONE;
              end
            endcase
          end
        end

        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_exp.sv
// Randomised self-checking bench for montgomery_exp with a behavioural
// Montgomery multiplier of programmable latency.
module tb_montgomery_exp;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_x = '0, in_e = '0, in_m = 8'hF1, in_r = 8'h0F, in_r2 = 8'hE1;
  logic [7:0] result;
  logic       done;

  montgomery_exp_if #(.WIDTH(8)) mm ();

  montgomery_exp #(.WIDTH(8), .EXP_WIDTH(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .in_x        (in_x),
    .in_e        (in_e),
    .in_m        (in_m),
    .in_r_mod_m  (in_r),
    .in_r2_mod_m (in_r2),
    .result      (result),
    .done        (done),
    .mm          (mm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         lat = 3;
  bit         lat_rand = 1'b0;
  int         n_issue = 0;
  int         stab_err = 0;
  bit         busy = 1'b0;
  int         cur_l = 0;
  int         wait_c = 0;
  logic [7:0] cap_a, cap_b, cap_m;

  function automatic int mont_ref(int a, int b, int m);
    int ri = 0;
    for (int i = 1; i < m; i++)
      if ((256 * i) % m == 1) ri = i;
    return (a * b * ri) % m;
  endfunction

  function automatic int pow_ref(int x, int e, int m);
    int r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * x) % m;
    return r;
  endfunction

  function automatic int nmul_ref(int e);
    int bl = 0;
    int pc = 0;
    if (e == 0) return 2;
    for (int i = 0; i < 8; i++)
      if (((e >> i) & 1) == 1) begin
        pc++;
        bl = i + 1;
      end
    return 2 + bl + pc;
  endfunction

  // Multiplier model: samples an issue on the falling edge, answers after cur_l
  // rising edges, and flags any operand change or extra start while busy.
  initial begin
    mm.mm_done   = 1'b0;
    mm.mm_result = '0;
    forever begin
      @(negedge clk);
      mm.mm_done = 1'b0;
      if (!resetn) begin
        busy = 1'b0;
      end else if (busy) begin
        if (mm.mm_start !== 1'b0 || mm.mm_a !== cap_a || mm.mm_b !== cap_b || mm.mm_m !== cap_m)
          stab_err++;
        if (wait_c >= cur_l) begin
          mm.mm_done   = 1'b1;
          mm.mm_result = 8'(mont_ref(int'(cap_a), int'(cap_b), int'(cap_m)));
          busy = 1'b0;
        end else begin
          wait_c++;
        end
      end else if (mm.mm_start === 1'b1) begin
        busy   = 1'b1;
        wait_c = 1;
        cur_l  = lat_rand ? int'($urandom_range(20, 1)) : lat;
        cap_a  = mm.mm_a;
        cap_b  = mm.mm_b;
        cap_m  = mm.mm_m;
        n_issue++;
      end
    end
  end

  // Called on a falling edge; returns edges from the accepting edge to done.
  task automatic run_op(input logic [7:0] x, input logic [7:0] e, input logic [7:0] m,
                        input int inject, output int cycles, output bit timeout);
    int r;
    r       = 256 % int'(m);
    in_x    = x;
    in_e    = e;
    in_m    = m;
    in_r    = 8'(r);
    in_r2   = 8'((r * r) % int'(m));
    n_issue = 0;
    stab_err = 0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    cycles  = 0;
    timeout = 1'b0;
    while (done !== 1'b1) begin
      if (cycles >= 3000) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
      if (inject != 0 && cycles == inject) begin
        start = 1'b1;
        in_x  = ~x;
        in_e  = ~e;
        in_m  = 8'hFB;
        in_r  = 8'h05;
        in_r2 = 8'h19;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({done, result, mm.mm_start, mm.mm_a, mm.mm_b, mm.mm_m} !== '0) begin
      errors++;
      $display("FAIL reset_values: done=%b result=%h mm_start=%b a=%h b=%h m=%h, required all 0",
               done, result, mm.mm_start, mm.mm_a, mm.mm_b, mm.mm_m);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [7:0] xs[4] = '{8'h03, 8'h03, 8'h00, 8'h02};
    logic [7:0] es[4] = '{8'h05, 8'h00, 8'h03, 8'hFF};
    int cyc;
    bit to;
    lat = 3;
    lat_rand = 1'b0;
    foreach (xs[i]) begin
      run_op(xs[i], es[i], 8'hF1, 0, cyc, to);
      checks++;
      if (to || result !== 8'(pow_ref(int'(xs[i]), int'(es[i]), 241))) begin
        errors++;
        $display("FAIL vec_result[%0d]: got %h timeout=%0d, required %h", i, result, to,
                 pow_ref(int'(xs[i]), int'(es[i]), 241));
      end
      checks++;
      if (n_issue !== nmul_ref(int'(es[i]))) begin
        errors++;
        $display("FAIL vec_mm_count[%0d]: got %0d, required %0d", i, n_issue, nmul_ref(int'(es[i])));
      end
      checks++;
      if (stab_err !== 0) begin
        errors++;
        $display("FAIL vec_operand_stability[%0d]: got %0d violations, required 0", i, stab_err);
      end
      if (es[i] == 8'h00) begin
        checks++;
        if (cyc !== 2 * (1 + lat) + 8 + 1) begin
          errors++;
          $display("FAIL zero_exp_latency: got %0d, required %0d", cyc, 2 * (1 + lat) + 8 + 1);
        end
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b1 || result !== 8'(pow_ref(2, 255, 241))) begin
      errors++;
      $display("FAIL done_held: done=%b result=%h, required 1 and %h", done, result, pow_ref(2, 255, 241));
    end
  endtask

  task automatic test_latency();
    int ls[3] = '{1, 7, 0};
    int cyc;
    bit to;
    foreach (ls[i]) begin
      lat      = ls[i];
      lat_rand = (ls[i] == 0);
      run_op(8'h03, 8'h05, 8'hF1, 0, cyc, to);
      checks++;
      if (to || result !== 8'h02 || n_issue !== 7 || stab_err !== 0) begin
        errors++;
        $display("FAIL latency[%0d]: result=%h issues=%0d stab=%0d timeout=%0d, required 02/7/0/0",
                 i, result, n_issue, stab_err, to);
      end
    end
    lat_rand = 1'b0;
  endtask

  task automatic test_random();
    int cyc;
    bit to;
    logic [7:0] m, x, e;
    for (int i = 0; i < 12; i++) begin
      m   = 8'($urandom_range(127, 1) * 2 + 1);
      x   = 8'($urandom_range(int'(m) - 1, 0));
      e   = 8'($urandom);
      lat = int'($urandom_range(5, 1));
      run_op(x, e, m, 0, cyc, to);
      checks++;
      if (to || result !== 8'(pow_ref(int'(x), int'(e), int'(m))) ||
          n_issue !== nmul_ref(int'(e)) || stab_err !== 0) begin
        errors++;
        $display("FAIL random[%0d] x=%h e=%h m=%h: result=%h issues=%0d stab=%0d to=%0d, required %h/%0d/0/0",
                 i, x, e, m, result, n_issue, stab_err, to,
                 pow_ref(int'(x), int'(e), int'(m)), nmul_ref(int'(e)));
      end
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    bit to;
    lat = 3;
    run_op(8'h03, 8'h05, 8'hF1, 10, cyc, to);
    checks++;
    if (to || result !== 8'h02 || n_issue !== 7) begin
      errors++;
      $display("FAIL ignore_start: result=%h issues=%0d to=%0d, required 02/7/0", result, n_issue, to);
    end
  endtask

  task automatic test_reset_midwait();
    int cyc;
    bit to;
    lat = 7;
    in_x = 8'h03; in_e = 8'h05; in_m = 8'hF1; in_r = 8'h0F; in_r2 = 8'hE1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mm.mm_start !== 1'b0 || mm.mm_a !== 8'h03 || mm.mm_b !== 8'hE1 || mm.mm_m !== 8'hF1) begin
      errors++;
      $display("FAIL tomont_wait_operands: start=%b a=%h b=%h m=%h, required 0/03/e1/f1",
               mm.mm_start, mm.mm_a, mm.mm_b, mm.mm_m);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({done, result, mm.mm_start, mm.mm_a, mm.mm_b, mm.mm_m} !== '0) begin
      errors++;
      $display("FAIL async_reset_midwait: done=%b result=%h mm_start=%b a=%h b=%h m=%h, required all 0",
               done, result, mm.mm_start, mm.mm_a, mm.mm_b, mm.mm_m);
    end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_op(8'h07, 8'h0B, 8'hF1, 0, cyc, to);
    checks++;
    if (to || result !== 8'(pow_ref(7, 11, 241)) || n_issue !== nmul_ref(11)) begin
      errors++;
      $display("FAIL restart_after_reset: result=%h issues=%0d to=%0d, required %h/%0d/0",
               result, n_issue, to, pow_ref(7, 11, 241), nmul_ref(11));
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit to;
    lat = 2;
    run_op(8'h05, 8'h09, 8'hF1, 0, cyc, to);
    run_op(8'h0A, 8'h21, 8'hF1, 0, cyc, to);
    checks++;
    if (to || result !== 8'(pow_ref(10, 33, 241)) || n_issue !== nmul_ref(33)) begin
      errors++;
      $display("FAIL back_to_back: result=%h issues=%0d to=%0d, required %h/%0d/0",
               result, n_issue, to, pow_ref(10, 33, 241), nmul_ref(33));
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_latency();
    test_random();
    test_ignore_start();
    test_reset_midwait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
